// File: rtl/uart_word_packer_pkg.sv
// uart_word_packer_pkg: shared constants for the UART word packer
package uart_word_packer_pkg;
  localparam int BYTES_DEFAULT = 4;
  localparam int CNT_W = 4;
endpackage

// File: rtl/uart_word_packer.sv
// uart_word_packer: packs FWFT UART FIFO bytes little-endian into BYTES-wide words
module uart_word_packer
  import uart_word_packer_pkg::*;
#(
  parameter int BYTES = BYTES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         fifo_dout,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic               clear,
  output logic [8*BYTES-1:0] word_data,
  output logic               word_valid,
  input  logic               word_ready,
  output logic [CNT_W-1:0]   partial_cnt,
  output logic [31:0]        word_count
);
  logic [8*(BYTES-1)-1:0] r_asm;
  logic [8*BYTES-1:0]     r_data;
  logic [8*BYTES-1:0]     w_full;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_valid;
  logic [31:0]            r_count;
  logic                   w_last;
  logic                   w_stall;
  logic                   w_pop;
  logic                   w_hand;
  // pop decision: the completing byte waits while an unconsumed word is held
  always_comb begin
    w_last = r_cnt == CNT_W'(BYTES - 1);
    w_stall = w_last && r_valid && !word_ready;
    w_pop = !fifo_empty && !clear && !w_stall && !rst;
    w_hand = r_valid && word_ready;
    w_full = {fifo_dout, r_asm};
  end
  // assembly register, output word register and handoff counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm <= '0;
      r_data <= '0;
      r_cnt <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      if (clear) r_cnt <= '0;
      else if (w_pop) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      for (int i = 0; i < BYTES - 1; i++)
        if (w_pop && !w_last && r_cnt == CNT_W'(i)) r_asm[8*i +: 8] <= fifo_dout;
      if (w_pop && w_last) begin
        r_data <= w_full;
        r_valid <= 1'b1;
      end else if (w_hand) r_valid <= 1'b0;
      if (w_hand) r_count <= r_count + 1'b1;
    end
  end
  assign fifo_rd_en = w_pop;
  assign word_data = r_data;
  assign word_valid = r_valid;
  assign partial_cnt = r_cnt;
  assign word_count = r_count;
endmodule
